// File: rtl/mole_pkg.sv
// Shared constants and helpers for the mole scheduler slice.
// Hole indices are 4 bits wide so that 15 can mean "no hit".
package mole_pkg;

  localparam int HOLES = 9;
  localparam logic [3:0] NO_HIT = 4'd15;

  typedef logic [3:0] hole_t;

  function automatic logic [3:0] popcnt9(input logic [HOLES-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < HOLES; i++) begin
      n = n + 4'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/mole_slot.sv
// One hole: an 8-bit life counter that is loaded, killed or
// decremented on each tick; it reports occupancy and expiry.
module mole_slot #(
  parameter int LIFE_TICKS = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic load,
  input  logic kill,
  input  logic tick,
  output logic active,
  output logic expire
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (kill) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = 8'(LIFE_TICKS);
    end else if (tick && cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign active = (cnt_q != 8'd0);
  // A hit on the same cycle wins over the timeout.
  assign expire = tick & ~kill & ~clear & (cnt_q == 8'd1);

endmodule

// File: rtl/mole_scheduler.sv
// Whack-a-mole scheduler: prescaler, spawn counter, free-hole
// picker, hit decode and the nine per-hole life slots.
module mole_scheduler
  import mole_pkg::*;
#(
  parameter int TICK_DIV    = 10_000_000,
  parameter int SPAWN_TICKS = 5,
  parameter int LIFE_TICKS  = 12,
  parameter int MAX_ACTIVE  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             clear,
  input  logic [8:0]       rnd,
  input  logic [3:0]       hit_pos,
  output logic [HOLES-1:0] map,
  output logic [3:0]       active_cnt,
  output logic             hit_pulse,
  output logic             whiff_pulse,
  output logic [HOLES-1:0] expired_mask,
  output logic             tick
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = (SPAWN_TICKS > 1) ? $clog2(SPAWN_TICKS) : 1;

  logic [PW-1:0]    psc_q, psc_d;
  logic [SW-1:0]    sp_q, sp_d;
  logic             tick_q;
  logic             hit_q, whiff_q;
  logic [HOLES-1:0] exp_q;
  logic [3:0]       cnt_q;

  logic             tick_ev, spawn_ev, room;
  logic             hit_ok, hit_on, found;
  logic [HOLES-1:0] hit_oh, kill_v, load_v, act_v, exp_v, map_d;
  hole_t            start;
  logic [4:0]       idx;
  logic             unused_rnd;

  assign unused_rnd = ^rnd[8:4];

  // tick_q mirrors "count == TICK_DIV-1"; it only acts while enabled.
  assign tick_ev  = enable & tick_q;
  assign spawn_ev = tick_ev & (sp_q == SW'(SPAWN_TICKS - 1));

  assign psc_d = (psc_q == PW'(TICK_DIV - 1)) ? '0 : psc_q + 1'b1;
  assign sp_d  = (sp_q == SW'(SPAWN_TICKS - 1)) ? '0 : sp_q + 1'b1;

  assign hit_ok = enable & (hit_pos < 4'd9);
  assign hit_oh = hit_ok ? (9'b1 << hit_pos) : '0;
  assign kill_v = hit_oh & map;
  assign hit_on = |kill_v;

  assign start = (rnd[3:0] < 4'd9) ? rnd[3:0] : rnd[3:0] - 4'd9;
  assign room  = (cnt_q < 4'(MAX_ACTIVE)) && (map != '1);

  always_comb begin
    load_v = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < HOLES; k++) begin
      idx = 5'(start) + 5'(k);
      if (idx >= 5'd9) idx = idx - 5'd9;
      if (!found && !map[idx]) begin
        load_v[idx] = 1'b1;
        found       = 1'b1;
      end
    end
    if (!(spawn_ev && room)) load_v = '0;
  end

  for (genvar i = 0; i < HOLES; i++) begin : g_slot
    mole_slot #(
      .LIFE_TICKS(LIFE_TICKS)
    ) u_slot (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .load  (load_v[i]),
      .kill  (kill_v[i]),
      .tick  (tick_ev),
      .active(act_v[i]),
      .expire(exp_v[i])
    );
  end

  assign map_d = (map & ~kill_v & ~exp_v) | load_v;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      psc_q   <= '0;
      sp_q    <= '0;
      tick_q  <= 1'b0;
      hit_q   <= 1'b0;
      whiff_q <= 1'b0;
      exp_q   <= '0;
      cnt_q   <= '0;
    end else if (clear) begin
      psc_q   <= '0;
      sp_q    <= '0;
      tick_q  <= 1'b0;
      hit_q   <= 1'b0;
      whiff_q <= 1'b0;
      exp_q   <= '0;
      cnt_q   <= '0;
    end else begin
      if (enable) begin
        psc_q  <= psc_d;
        tick_q <= (psc_d == PW'(TICK_DIV - 1));
        if (tick_ev) sp_q <= sp_d;
      end
      hit_q   <= hit_on;
      whiff_q <= hit_ok & ~hit_on;
      exp_q   <= exp_v;
      cnt_q   <= popcnt9(map_d);
    end
  end

  assign map          = act_v;
  assign active_cnt   = cnt_q;
  assign hit_pulse    = hit_q;
  assign whiff_pulse  = whiff_q;
  assign expired_mask = exp_q;
  assign tick         = tick_q;

endmodule

// File: tb/tb_mole_scheduler.sv
// Directed plus randomized bench for mole_scheduler against an
// array-based game model of holes, lifetimes and tick counts.
module tb_mole_scheduler;
  import mole_pkg::*;

  localparam int TD = 4;
  localparam int ST = 2;
  localparam int LT = 5;
  localparam int MA = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic       clear = 1'b0;
  logic [8:0] rnd = '0;
  logic [3:0] hit_pos = NO_HIT;
  logic [8:0] map;
  logic [3:0] active_cnt;
  logic       hit_pulse;
  logic       whiff_pulse;
  logic [8:0] expired_mask;
  logic       tick;

  mole_scheduler #(
    .TICK_DIV(TD), .SPAWN_TICKS(ST),
    .LIFE_TICKS(LT), .MAX_ACTIVE(MA)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear),
    .rnd(rnd), .hit_pos(hit_pos), .map(map),
    .active_cnt(active_cnt), .hit_pulse(hit_pulse),
    .whiff_pulse(whiff_pulse), .expired_mask(expired_mask),
    .tick(tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int         life [9];
  int         m_psc;
  int         m_ticks;
  logic [8:0] e_exp;
  logic       e_hit, e_whiff, e_tick;

  function automatic logic [8:0] m_map();
    logic [8:0] v;
    v = '0;
    for (int i = 0; i < 9; i++) if (life[i] > 0) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [8:0] m_cnt();
    int n;
    n = 0;
    for (int i = 0; i < 9; i++) if (life[i] > 0) n++;
    return 9'(n);
  endfunction

  task automatic chk(input string tag, input logic [8:0] got,
                     input logic [8:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 9; i++) life[i] = 0;
    m_psc = 0; m_ticks = 0;
    e_exp = '0; e_hit = 0; e_whiff = 0; e_tick = 0;
  endtask

  task automatic m_step(input logic en, input logic clr,
                        input logic [8:0] r, input logic [3:0] h);
    int  old [9];
    int  n, s, j;
    bit  ticking, got;
    if (clr) begin
      m_reset();
      return;
    end
    e_hit = 0; e_whiff = 0; e_exp = '0;
    if (!en) return;
    for (int i = 0; i < 9; i++) old[i] = life[i];
    ticking = (m_psc == TD - 1);
    m_psc   = (m_psc + 1) % TD;
    e_tick  = (m_psc == TD - 1);
    if (h < 9) begin
      if (old[h] > 0) begin life[h] = 0; e_hit = 1; end
      else e_whiff = 1;
    end
    if (ticking) begin
      for (int i = 0; i < 9; i++) begin
        if (old[i] > 0 && !(e_hit && i == int'(h))) begin
          life[i]--;
          if (life[i] == 0) e_exp[i] = 1'b1;
        end
      end
      m_ticks++;
      if (m_ticks % ST == 0) begin
        n = 0;
        for (int i = 0; i < 9; i++) if (old[i] > 0) n++;
        if (n < MA && n < 9) begin
          s = int'(r[3:0]);
          if (s >= 9) s -= 9;
          got = 0;
          for (int k = 0; k < 9; k++) begin
            j = (s + k) % 9;
            if (!got && old[j] == 0) begin
              life[j] = LT;
              got = 1;
            end
          end
        end
      end
    end
  endtask

  task automatic step(input logic en, input logic clr,
                      input logic [8:0] r, input logic [3:0] h);
    @(negedge clk);
    enable = en; clear = clr; rnd = r; hit_pos = h;
    m_step(en, clr, r, h);
    @(posedge clk);
    #1;
    chk("map", map, m_map());
    chk("active_cnt", 9'(active_cnt), m_cnt());
    chk("hit_pulse", 9'(hit_pulse), 9'(e_hit));
    chk("whiff_pulse", 9'(whiff_pulse), 9'(e_whiff));
    chk("expired_mask", expired_mask, e_exp);
    chk("tick", 9'(tick), 9'(e_tick));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_map"}, map, '0);
    chk({tag, "_cnt"}, 9'(active_cnt), '0);
    chk({tag, "_hit"}, 9'(hit_pulse), '0);
    chk({tag, "_whiff"}, 9'(whiff_pulse), '0);
    chk({tag, "_exp"}, expired_mask, '0);
    chk({tag, "_tick"}, 9'(tick), '0);
  endtask

  initial begin
    int  target;
    bit  done;
    int  budget;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    repeat (8) step(1, 0, 9'h005, NO_HIT);
    chk("first_spawn_map", map, 9'h020);
    chk("first_spawn_cnt", 9'(active_cnt), 9'd1);
    repeat (16) step(1, 0, 9'h005, NO_HIT);
    chk("cap_map", map, 9'h060);
    chk("cap_hit", 9'(hit_pulse), '0);
    repeat (4) step(1, 0, 9'h005, NO_HIT);
    chk("expiry_mask", expired_mask, 9'h020);
    chk("expiry_map", map, 9'h040);

    step(1, 0, 9'h005, 4'd6);
    chk("hit_pulse6", 9'(hit_pulse), 9'd1);
    chk("hit_map", map, 9'h000);
    step(1, 0, 9'h005, 4'd6);
    chk("whiff6", 9'(whiff_pulse), 9'd1);
    chk("whiff_nohit", 9'(hit_pulse), '0);

    repeat (10) step(1, 0, 9'h00C, NO_HIT);
    chk("wrap_pick_map", map, 9'h018);

    done = 0; budget = 0;
    while (!done && budget < 200) begin
      target = -1;
      if (m_psc == TD - 1)
        for (int i = 0; i < 9; i++) if (life[i] == 1) target = i;
      if (target >= 0) begin
        step(1, 0, 9'($urandom), 4'(target));
        chk("race_hit", 9'(hit_pulse), 9'd1);
        chk("race_noexp", 9'(expired_mask[target]), '0);
        done = 1;
      end else begin
        step(1, 0, 9'($urandom), NO_HIT);
      end
      budget++;
    end
    chk("race_found", 9'(done), 9'd1);

    budget = 0;
    while (m_psc != TD - 1 && budget < 10) begin
      step(1, 0, 9'($urandom), NO_HIT);
      budget++;
    end
    chk("pause_tick_high", 9'(tick), 9'd1);
    repeat (20) step(0, 0, 9'($urandom), 4'($urandom_range(0, 8)));
    chk("pause_tick_held", 9'(tick), 9'd1);
    step(1, 1, 9'($urandom), NO_HIT);
    chk_zero("clear");

    repeat (13) step(1, 0, 9'h003, NO_HIT);
    #2;
    rst = 1'b0;
    #1;
    chk_zero("async_rst");
    m_reset();
    rst = 1'b1;

    repeat (800) begin
      step(($urandom % 10) != 0, ($urandom % 80) == 0, 9'($urandom),
           (($urandom % 3) == 0) ? 4'($urandom) : NO_HIT);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
